// File: rtl/aurora_ll_frame_checker.sv
// aurora_ll_frame_checker
// Receive-side LocalLink frame checker for the Aurora loopback design.
// Tracks SOF/EOF framing and regenerates the 16-bit LFSR sequence of the
// frame generator on the far end of the link. Each received word is compared
// against that sequence, and the block reports word and framing errors.
//
// Ports:
//   USER_CLK      Aurora user clock (sole clock)
//   RESET         synchronous active-high reset
//   CHANNEL_UP    channel up; while low the block is held in reset
//   RX_D[0:15]    received data, bit 0 = MSB, [0:7] = first byte
//   RX_REM        EOF word only: 1 = both bytes valid, 0 = first byte only
//   RX_SOF_N      start of frame, active low
//   RX_EOF_N      end of frame, active low
//   RX_SRC_RDY_N  word valid, active low (never back-pressured)
//   DATA_ERR      one-cycle pulse, compared word mismatched
//   FRAME_ERR     one-cycle pulse, framing violation
//   ERR_COUNT     mismatched word count, saturates at 255
//   FRAME_COUNT   completed frame count, wraps
//   IN_FRAME      high between an accepted SOF and its EOF
module aurora_ll_frame_checker #(
  parameter logic [15:0] LFSR_SEED   = 16'hD5E6,
  parameter int          FRAME_CNT_W = 16
) (
  input  logic                   USER_CLK,
  input  logic                   RESET,
  input  logic                   CHANNEL_UP,
  input  logic [0:15]            RX_D,
  input  logic                   RX_REM,
  input  logic                   RX_SOF_N,
  input  logic                   RX_EOF_N,
  input  logic                   RX_SRC_RDY_N,
  output logic                   DATA_ERR,
  output logic                   FRAME_ERR,
  output logic [0:7]             ERR_COUNT,
  output logic [FRAME_CNT_W-1:0] FRAME_COUNT,
  output logic                   IN_FRAME
);

  typedef enum logic {IDLE, IN_FRM} state_t;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[14] ^ l[12] ^ l[3];
    return {l[14:0], fb};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic                   rst_i;
  logic                   beat;
  logic                   sof;
  logic                   eof;
  state_t                 state_p1;
  state_t                 state_nxt;
  logic [15:0]            lfsr_p1;
  logic                   data_err_p1;
  logic                   frame_err_p1;
  logic [7:0]             err_cnt_p1;
  logic [FRAME_CNT_W-1:0] frame_cnt_p1;
  logic                   cmp;
  logic                   frm_err;
  logic                   frame_done;
  logic                   mismatch;

  assign rst_i = RESET | ~CHANNEL_UP;
  assign beat  = ~RX_SRC_RDY_N;
  assign sof   = ~RX_SOF_N;
  assign eof   = ~RX_EOF_N;

  // Framing decisions for the current beat
  always_comb begin
    state_nxt  = state_p1;
    cmp        = 1'b0;
    frm_err    = 1'b0;
    frame_done = 1'b0;
    if (beat) begin
      case (state_p1)
        IDLE: begin
          if (sof) begin
            cmp = 1'b1;
            if (eof) frame_done = 1'b1;
            else     state_nxt  = IN_FRM;
          end else begin
            // Data outside a frame: flagged, not compared, LFSR held
            frm_err = 1'b1;
          end
        end
        IN_FRM: begin
          cmp = 1'b1;
          // A new SOF aborts the open frame and starts a new one on this beat
          if (sof) frm_err = 1'b1;
          if (eof) begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Short EOF word carries only the first byte, checked against the LFSR MSBs
  always_comb begin
    mismatch = 1'b0;
    if (cmp) begin
      if (eof && !RX_REM) mismatch = (RX_D[0:7] != lfsr_p1[15:8]);
      else                mismatch = (RX_D != lfsr_p1);
    end
  end

  // Stage p1: all state and status outputs registered on the beat's edge
  always_ff @(posedge USER_CLK) begin
    if (rst_i) begin
      state_p1     <= IDLE;
      lfsr_p1      <= LFSR_SEED;
      data_err_p1  <= 1'b0;
      frame_err_p1 <= 1'b0;
      err_cnt_p1   <= 8'd0;
      frame_cnt_p1 <= '0;
    end else begin
      state_p1     <= state_nxt;
      data_err_p1  <= mismatch;
      frame_err_p1 <= frm_err;
      if (cmp)        lfsr_p1      <= lfsr_step(lfsr_p1);
      if (mismatch)   err_cnt_p1   <= sat_inc8(err_cnt_p1);
      if (frame_done) frame_cnt_p1 <= frame_cnt_p1 + 1'b1;
    end
  end

  assign DATA_ERR    = data_err_p1;
  assign FRAME_ERR   = frame_err_p1;
  assign ERR_COUNT   = err_cnt_p1;
  assign FRAME_COUNT = frame_cnt_p1;
  assign IN_FRAME    = (state_p1 == IN_FRM);

endmodule

// File: tb/tb_aurora_ll_frame_checker.sv
module tb_aurora_ll_frame_checker;

  logic        USER_CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        CHANNEL_UP = 1'b1;
  logic [0:15] RX_D = 16'h0000;
  logic        RX_REM = 1'b1;
  logic        RX_SOF_N = 1'b1;
  logic        RX_EOF_N = 1'b1;
  logic        RX_SRC_RDY_N = 1'b1;
  logic        DATA_ERR;
  logic        FRAME_ERR;
  logic [0:7]  ERR_COUNT;
  logic [15:0] FRAME_COUNT;
  logic        IN_FRAME;

  int checks = 0;
  int errors = 0;

  aurora_ll_frame_checker #(.LFSR_SEED(16'hD5E6), .FRAME_CNT_W(16)) dut (
    .USER_CLK(USER_CLK), .RESET(RESET), .CHANNEL_UP(CHANNEL_UP),
    .RX_D(RX_D), .RX_REM(RX_REM), .RX_SOF_N(RX_SOF_N), .RX_EOF_N(RX_EOF_N),
    .RX_SRC_RDY_N(RX_SRC_RDY_N), .DATA_ERR(DATA_ERR), .FRAME_ERR(FRAME_ERR),
    .ERR_COUNT(ERR_COUNT), .FRAME_COUNT(FRAME_COUNT), .IN_FRAME(IN_FRAME)
  );

  always #5 USER_CLK = ~USER_CLK;

  // Hand-derived sequence from seed D5E6
  localparam logic [15:0] W0 = 16'hD5E6, W1 = 16'hABCD, W2 = 16'h579A, W3 = 16'hAF35;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[14] ^ l[12] ^ l[3]};
  endfunction

  // Present one beat for one edge, then idle the bus; returns 1 time unit after the edge
  task automatic beat(input logic [15:0] d, input logic sof, input logic eof, input logic rem);
    RX_D = d; RX_SOF_N = ~sof; RX_EOF_N = ~eof; RX_REM = rem; RX_SRC_RDY_N = 1'b0;
    @(posedge USER_CLK); #1;
    RX_SRC_RDY_N = 1'b1; RX_SOF_N = 1'b1; RX_EOF_N = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge USER_CLK); #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    // Garbage on the bus during reset must not matter
    RX_SOF_N = 1'b0; RX_SRC_RDY_N = 1'b0; RX_D = 16'h1234;
    do_reset();
    RX_SOF_N = 1'b1; RX_SRC_RDY_N = 1'b1;
    checks++; if (DATA_ERR !== 1'b0) begin errors++; $display("FAIL rst_data_err got %b want 0", DATA_ERR); end
    checks++; if (FRAME_ERR !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", FRAME_ERR); end
    checks++; if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL rst_err_count got %0d want 0", ERR_COUNT); end
    checks++; if (FRAME_COUNT !== 16'd0) begin errors++; $display("FAIL rst_frame_count got %0d want 0", FRAME_COUNT); end
    checks++; if (IN_FRAME !== 1'b0) begin errors++; $display("FAIL rst_in_frame got %b want 0", IN_FRAME); end
  endtask

  task automatic test_clean_frame();
    logic [15:0] w [4];
    logic        exp_in [4];
    w = '{W0, W1, W2, W3};
    exp_in = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(w[i], i == 0, i == 3, 1'b1);
      checks++; if (DATA_ERR !== 1'b0 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL clean_pulse beat %0d got d=%b f=%b want 0 0", i, DATA_ERR, FRAME_ERR); end
      checks++; if (IN_FRAME !== exp_in[i]) begin errors++; $display("FAIL clean_in_frame beat %0d got %b want %b", i, IN_FRAME, exp_in[i]); end
    end
    checks++; if (FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL clean_frame_count got %0d want 1", FRAME_COUNT); end
    checks++; if (ERR_COUNT !== 8'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", ERR_COUNT); end
    // Idle cycles with stray control levels change nothing
    RX_SOF_N = 1'b0; RX_EOF_N = 1'b0; RX_D = 16'hFFFF;
    repeat (3) @(posedge USER_CLK); #1;
    RX_SOF_N = 1'b1; RX_EOF_N = 1'b1;
    checks++; if (FRAME_COUNT !== 16'd1 || FRAME_ERR !== 1'b0 || IN_FRAME !== 1'b0) begin errors++; $display("FAIL idle_hold got fc=%0d fe=%b in=%b want 1 0 0", FRAME_COUNT, FRAME_ERR, IN_FRAME); end
    // Sequence continues across frames: next frame starts at AF35's successor 5E6B
    beat(16'h5E6B, 1'b1, 1'b1, 1'b1);
    checks++; if (DATA_ERR !== 1'b0 || FRAME_COUNT !== 16'd2) begin errors++; $display("FAIL continuous_lfsr got d=%b fc=%0d want 0 2", DATA_ERR, FRAME_COUNT); end
  endtask

  task automatic test_data_err();
    logic [15:0] w [4];
    logic        exp_de [4];
    w = '{W0, 16'hABCC, W2, W3};
    exp_de = '{1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(w[i], i == 0, i == 3, 1'b1);
      checks++; if (DATA_ERR !== exp_de[i]) begin errors++; $display("FAIL derr_pulse beat %0d got %b want %b", i, DATA_ERR, exp_de[i]); end
    end
    checks++; if (ERR_COUNT !== 8'd1) begin errors++; $display("FAIL derr_err_count got %0d want 1", ERR_COUNT); end
    checks++; if (FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL derr_frame_count got %0d want 1", FRAME_COUNT); end
  endtask

  task automatic test_single_word();
    do_reset();
    beat(16'hD500, 1'b1, 1'b1, 1'b0);
    checks++; if (DATA_ERR !== 1'b0) begin errors++; $display("FAIL short_rem got %b want 0", DATA_ERR); end
    checks++; if (FRAME_COUNT !== 16'd1 || IN_FRAME !== 1'b0) begin errors++; $display("FAIL short_frame got fc=%0d in=%b want 1 0", FRAME_COUNT, IN_FRAME); end
    beat(W1, 1'b1, 1'b1, 1'b1);
    checks++; if (DATA_ERR !== 1'b0 || FRAME_COUNT !== 16'd2) begin errors++; $display("FAIL short_next got d=%b fc=%0d want 0 2", DATA_ERR, FRAME_COUNT); end
    // Short EOF with wrong first byte is caught; low byte still ignored
    beat(16'h58FF, 1'b1, 1'b1, 1'b0);
    checks++; if (DATA_ERR !== 1'b1 || ERR_COUNT !== 8'd1) begin errors++; $display("FAIL short_bad got d=%b ec=%0d want 1 1", DATA_ERR, ERR_COUNT); end
  endtask

  task automatic test_no_sof();
    do_reset();
    beat(W0, 1'b0, 1'b0, 1'b1);
    checks++; if (FRAME_ERR !== 1'b1 || DATA_ERR !== 1'b0) begin errors++; $display("FAIL nosof_pulse got f=%b d=%b want 1 0", FRAME_ERR, DATA_ERR); end
    beat(W0, 1'b1, 1'b0, 1'b1);
    checks++; if (FRAME_ERR !== 1'b0 || DATA_ERR !== 1'b0 || IN_FRAME !== 1'b1) begin errors++; $display("FAIL nosof_restart got f=%b d=%b in=%b want 0 0 1", FRAME_ERR, DATA_ERR, IN_FRAME); end
    beat(W1, 1'b0, 1'b1, 1'b1);
    checks++; if (DATA_ERR !== 1'b0 || FRAME_COUNT !== 16'd1 || ERR_COUNT !== 8'd0) begin errors++; $display("FAIL nosof_end got d=%b fc=%0d ec=%0d want 0 1 0", DATA_ERR, FRAME_COUNT, ERR_COUNT); end
  endtask

  task automatic test_sof_in_frame();
    do_reset();
    beat(W0, 1'b1, 1'b0, 1'b1);
    beat(W1, 1'b0, 1'b0, 1'b1);
    beat(W2, 1'b1, 1'b0, 1'b1);
    checks++; if (FRAME_ERR !== 1'b1 || DATA_ERR !== 1'b0 || IN_FRAME !== 1'b1) begin errors++; $display("FAIL resof_pulse got f=%b d=%b in=%b want 1 0 1", FRAME_ERR, DATA_ERR, IN_FRAME); end
    checks++; if (FRAME_COUNT !== 16'd0) begin errors++; $display("FAIL resof_abort_count got %0d want 0", FRAME_COUNT); end
    // Back-to-back SOF+EOF while in a frame: both errors in one cycle, one count
    beat(16'h0000, 1'b1, 1'b1, 1'b1);
    checks++; if (FRAME_ERR !== 1'b1 || DATA_ERR !== 1'b1 || ERR_COUNT !== 8'd1) begin errors++; $display("FAIL resof_both got f=%b d=%b ec=%0d want 1 1 1", FRAME_ERR, DATA_ERR, ERR_COUNT); end
    checks++; if (FRAME_COUNT !== 16'd1 || IN_FRAME !== 1'b0) begin errors++; $display("FAIL resof_single got fc=%0d in=%b want 1 0", FRAME_COUNT, IN_FRAME); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp;
    int          pulses;
    exp = W0;
    pulses = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      beat(~exp, i == 0, i == 299, 1'b1);
      if (DATA_ERR === 1'b1) pulses++;
      exp = lfsr_next(exp);
      if (i == 253) begin
        checks++; if (ERR_COUNT !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", ERR_COUNT); end
      end
      if (i == 254) begin
        checks++; if (ERR_COUNT !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d want 255", ERR_COUNT); end
      end
    end
    checks++; if (pulses != 300) begin errors++; $display("FAIL sat_pulses got %0d want 300", pulses); end
    checks++; if (ERR_COUNT !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", ERR_COUNT); end
    checks++; if (FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL sat_frame_count got %0d want 1", FRAME_COUNT); end
    // LFSR still tracks after saturation
    beat(exp, 1'b1, 1'b1, 1'b1);
    checks++; if (DATA_ERR !== 1'b0 || ERR_COUNT !== 8'd255) begin errors++; $display("FAIL sat_track got d=%b ec=%0d want 0 255", DATA_ERR, ERR_COUNT); end
  endtask

  task automatic test_mid_frame_reset(input bit use_chan);
    do_reset();
    beat(W0, 1'b1, 1'b1, 1'b1);
    beat(16'h0000, 1'b1, 1'b0, 1'b1);
    checks++; if (FRAME_COUNT !== 16'd1 || ERR_COUNT !== 8'd1 || IN_FRAME !== 1'b1) begin errors++; $display("FAIL mid_pre%0d got fc=%0d ec=%0d in=%b want 1 1 1", use_chan, FRAME_COUNT, ERR_COUNT, IN_FRAME); end
    if (use_chan) CHANNEL_UP = 1'b0; else RESET = 1'b1;
    @(posedge USER_CLK); #1;
    CHANNEL_UP = 1'b1; RESET = 1'b0;
    checks++; if (DATA_ERR !== 1'b0 || FRAME_ERR !== 1'b0 || ERR_COUNT !== 8'd0 || FRAME_COUNT !== 16'd0 || IN_FRAME !== 1'b0) begin
      errors++; $display("FAIL mid_rst%0d got d=%b f=%b ec=%0d fc=%0d in=%b want all 0", use_chan, DATA_ERR, FRAME_ERR, ERR_COUNT, FRAME_COUNT, IN_FRAME); end
    beat(W0, 1'b1, 1'b0, 1'b1);
    beat(W1, 1'b0, 1'b1, 1'b0 == 1'b1);
    checks++; if (DATA_ERR !== 1'b0 || ERR_COUNT !== 8'd0 || FRAME_COUNT !== 16'd1) begin errors++; $display("FAIL mid_after%0d got d=%b ec=%0d fc=%0d want 0 0 1", use_chan, DATA_ERR, ERR_COUNT, FRAME_COUNT); end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_data_err();
    test_single_word();
    test_no_sof();
    test_sof_in_frame();
    test_saturation();
    test_mid_frame_reset(1'b1);
    test_mid_frame_reset(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aurora_ll_frame_checker.md
Name: aurora_ll_frame_checker

Overview:
- Receive-side LocalLink frame checker for the Aurora loopback design; pairs with the LFSR frame generator on the opposite link end.
- Tracks SOF/EOF framing, regenerates the generator's 16-bit LFSR sequence, and compares each received word against it.
- Reports word errors, framing errors, a saturating error count and a received-frame count.
- Sits between the Aurora core RX LocalLink port and the top-level error/status outputs, in the USER_CLK domain.

Parameters:
- LFSR_SEED, 16'hD5E6, LFSR value after reset. Must be nonzero and must match the generator seed.
- FRAME_CNT_W, 16, width of the FRAME_COUNT output.

Ports:
- USER_CLK  in  1  Aurora user clock. Sole clock.
- RESET  in  1  synchronous, active-high reset.
- CHANNEL_UP  in  1  Aurora channel up. While low, the block is held in reset exactly as if RESET were high.
- RX_D  in  [0:15]  received data. Bit 0 is the MSB; bits [0:7] are the first byte.
- RX_REM  in  1  valid on the EOF word only. 1 = both bytes valid; 0 = only RX_D[0:7] valid.
- RX_SOF_N  in  1  start of frame, active low.
- RX_EOF_N  in  1  end of frame, active low.
- RX_SRC_RDY_N  in  1  word valid, active low. The checker never back-pressures.
- DATA_ERR  out  1  one-cycle pulse: a compared word mismatched.
- FRAME_ERR  out  1  one-cycle pulse: framing violation.
- ERR_COUNT  out  [0:7]  count of mismatched words; saturates at 255.
- FRAME_COUNT  out  FRAME_CNT_W  count of completed frames; wraps modulo 2^FRAME_CNT_W.
- IN_FRAME  out  1  high while between an accepted SOF and its EOF.

Behaviour:
- Effective reset: rst_i = RESET | ~CHANNEL_UP, sampled on the USER_CLK rising edge.
  - Reset values: state=IDLE, lfsr=LFSR_SEED, DATA_ERR=0, FRAME_ERR=0, ERR_COUNT=0, FRAME_COUNT=0, IN_FRAME=0.
  - Reset mid-frame discards the partial frame; no counter increments for it.
- Beat: a cycle with RX_SRC_RDY_N=0. Cycles with RX_SRC_RDY_N=1 change nothing; SOF/EOF/REM are ignored on them.
- LFSR, numeric indexing with bit 15 = MSB:
  - fb = l[15]^l[14]^l[12]^l[3]; next = {l[14:0], fb}.
  - Advances exactly once per compared beat. Continuous across frames; not reseeded per frame.
  - Sequence from the default seed: D5E6, ABCD, ...
- State machine, IDLE / IN_FRM:
  - IDLE, beat with SOF=0: compare, advance. EOF=0 on the same beat is a single-word frame: FRAME_COUNT+1, stay IDLE. Otherwise go to IN_FRM.
  - IDLE, beat with SOF=1: not compared, LFSR not advanced, FRAME_ERR pulse, stay IDLE.
  - IN_FRM, beat, SOF=1, EOF=1: compare, advance, stay.
  - IN_FRM, beat, EOF=0, SOF=1: compare, advance, FRAME_COUNT+1, go to IDLE.
  - IN_FRM, beat with SOF=0 (new SOF before EOF): FRAME_ERR pulse. The aborted frame is not counted. The beat is treated as the first word of a new frame: compare, advance. If EOF=0 on the same beat, FRAME_COUNT+1 and go to IDLE; otherwise stay in IN_FRM.
  - IN_FRM = IN_FRAME output, registered.
- Compare:
  - Non-EOF beat, or EOF with REM=1: all 16 bits of RX_D against lfsr.
  - EOF with REM=0: RX_D[0:7] against lfsr[15:8] only.
  - Mismatch: DATA_ERR pulse; ERR_COUNT+1 unless already 255.
- Latency: DATA_ERR, FRAME_ERR, ERR_COUNT, FRAME_COUNT and IN_FRAME all update on the clock edge that samples the beat. They are visible the cycle after the beat is presented. All outputs are registered.
- Simultaneous events: FRAME_ERR and DATA_ERR may pulse in the same cycle. A single beat increments ERR_COUNT by at most 1.

Test Plan:
- Reset with CHANNEL_UP=1, then a 4-beat frame D5E6, ABCD, then the next two LFSR words (EOF on beat 4, REM=1) -> FRAME_COUNT=1, ERR_COUNT=0, no DATA_ERR or FRAME_ERR pulse, IN_FRAME high for beats 2-4.
- Same frame with beat 2 = ABCC -> exactly one DATA_ERR pulse, one cycle after beat 2; ERR_COUNT=1; FRAME_COUNT=1.
- Single beat D5E6 with SOF=0, EOF=0, REM=0 and low byte 00 -> no error; next expected word is ABCD.
- Beat without SOF while IDLE -> FRAME_ERR pulse; a following SOF frame starting at D5E6 checks clean.
- 300 consecutive mismatching beats in one frame -> ERR_COUNT stops at 255, DATA_ERR pulses 300 times.
- Deassert CHANNEL_UP for 1 cycle mid-frame -> all outputs at reset values; next frame must start at D5E6 and checks clean. Repeat using RESET instead of CHANNEL_UP.
